dice_roll_ctrl: RTL and testbench

Roll sequencer for the TTRPG dice roller. Sits between the seven debounced die buttons and the digit-counter datapath: arbitrates button presses, issues load/step commands to the counter, runs a decelerating "tumble" after release, then shows the result and blanks the display after a timeout. Replaces the datapath's free-running decrement-while-held behaviour with a single sequenced roll.

---
 rtl/dice_pkg.sv | 32 +++
 rtl/dice_roll_ctrl_if.sv | 27 ++
 rtl/roll_timer.sv | 26 ++
 rtl/dice_roll_ctrl.sv | 115 +++++++++++
 tb/tb_dice_roll_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/dice_pkg.sv
// Shared types for the dice roll sequencer: FSM states, die indices,
// button count and the lowest-set-bit arbiter helper.
package dice_pkg;

  localparam int NBTN = 7;

  typedef enum logic [1:0] {
    SHOW   = 2'd0,
    SPIN   = 2'd1,
    TUMBLE = 2'd2,
    SLEEP  = 2'd3
  } roll_state_t;

  localparam logic [2:0] D4   = 3'd0;
  localparam logic [2:0] D6   = 3'd1;
  localparam logic [2:0] D8   = 3'd2;
  localparam logic [2:0] D10  = 3'd3;
  localparam logic [2:0] D12  = 3'd4;
  localparam logic [2:0] D20  = 3'd5;
  localparam logic [2:0] D100 = 3'd6;

  function automatic logic [2:0] lowest(
    input logic [NBTN-1:0] v
  );
    logic [2:0] r;
    r = D4;
    for (int i = NBTN - 1; i >= 0; i--)
      if (v[i]) r = 3'(i);
    return r;
  endfunction

endpackage

// File: rtl/dice_roll_ctrl_if.sv
// Button/prescaler inputs and counter/display commands of the roller.
// master: drives btn, tick; slave: the sequencer, drives the rest.
interface dice_roll_ctrl_if;
  import dice_pkg::*;

  logic            tick;
  logic [NBTN-1:0] btn;
  logic            load;
  logic [2:0]      die_sel;
  logic            step;
  logic            disp_on;
  logic            busy;
  roll_state_t     state;

  modport master (
    output tick, btn,
    input  load, die_sel, step,
    input  disp_on, busy, state
  );

  modport slave (
    input  tick, btn,
    output load, die_sel, step,
    output disp_on, busy, state
  );

endinterface

// File: rtl/roll_timer.sv
// Tick-gated counter: hit fires on the tick that reaches cmp, and the
// count restarts from zero. Ports: clk, rst, clr, tick, cmp -> hit.
module roll_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         tick,
  input  logic [W-1:0] cmp,
  output logic         hit
);

  logic [W-1:0] cnt;

  // clr wins over a coincident tick: that tick is discarded
  assign hit = tick && !clr && (cnt + 1'b1 == cmp);

  always_ff @(posedge clk) begin
    if (rst || clr || hit)
      cnt <= '0;
    else if (tick)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/dice_roll_ctrl.sv
// Roll sequencer: arbitrates die buttons, issues load/step to the
// digit counter, tumbles after release, then shows and sleeps.
module dice_roll_ctrl
  import dice_pkg::*;
#(
  parameter int TUMBLE_STEPS = 8,
  parameter int SHOW_TICKS   = 320
) (
  input logic             clk,
  input logic             rst,
  dice_roll_ctrl_if.slave bus
);

  localparam int SW = $clog2(SHOW_TICKS + 1);
  localparam int TW = (SW > 4) ? SW : 4;
  localparam logic [TW-1:0] SHOW_CMP = TW'(SHOW_TICKS);
  localparam logic [3:0] LAST_K = 4'(TUMBLE_STEPS - 1);

  roll_state_t     state_q, state_d;
  logic [NBTN-1:0] btn_q, rise;
  logic [2:0]      die_q;
  logic [3:0]      k_q;
  logic            press, held;
  logic            clr, hit;
  logic [TW-1:0]   cmp;
  logic            load_d, step_d;
  logic            disp_d, busy_d;
  logic            load_q, step_q;
  logic            disp_q, busy_q;

  assign rise  = bus.btn & ~btn_q;
  assign press = |rise;
  assign held  = bus.btn[die_q];

  // One timer serves both the tumble interval and the show timeout;
  // it is held clear wherever neither is running.
  assign clr = press || state_q == SPIN
            || state_q == SLEEP;
  assign cmp = (state_q == TUMBLE)
             ? TW'(k_q) + TW'(1) : SHOW_CMP;

  roll_timer #(.W(TW)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (bus.tick),
    .cmp  (cmp),
    .hit  (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SHOW;
      btn_q   <= '0;
      die_q   <= D4;
      k_q     <= '0;
      load_q  <= 1'b0;
      step_q  <= 1'b0;
      disp_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q   <= bus.btn;
      if (load_d)
        die_q <= lowest(rise);
      if (state_q == SPIN)
        k_q <= '0;
      else if (state_q == TUMBLE && hit)
        k_q <= k_q + 4'd1;
      load_q <= load_d;
      step_q <= step_d;
      disp_q <= disp_d;
      busy_q <= busy_d;
    end
  end

  // Rises during SPIN are ignored; btn_q absorbs them anyway.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SHOW:
        if (press)    state_d = SPIN;
        else if (hit) state_d = SLEEP;
      SPIN:
        if (!held)    state_d = TUMBLE;
      TUMBLE:
        if (press)    state_d = SPIN;
        else if (hit && k_q == LAST_K)
                      state_d = SHOW;
      SLEEP:
        if (press)    state_d = SPIN;
      default:        state_d = SHOW;
    endcase
  end

  always_comb begin
    load_d = press && state_q != SPIN;
    step_d = 1'b0;
    unique case (1'b1)
      state_q == SPIN:   step_d = held;
      state_q == TUMBLE: step_d = hit;
      default:           step_d = 1'b0;
    endcase
    disp_d = state_d == SHOW || state_d == TUMBLE;
    busy_d = state_d == SPIN || state_d == TUMBLE;
  end

  assign bus.state   = state_q;
  assign bus.die_sel = die_q;
  assign bus.load    = load_q;
  assign bus.step    = step_q;
  assign bus.disp_on = disp_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Bench for dice_roll_ctrl: vector table, directed roll sequences and
// random stimulus against a tick-schedule reference model.
module tb_dice_roll_ctrl;

  localparam int N  = 8;
  localparam int ST = 320;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dice_roll_ctrl_if bus();

  dice_roll_ctrl #(
    .TUMBLE_STEPS (N),
    .SHOW_TICKS   (ST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int pass_n  = 0;
  int total_n = 0;

  typedef struct {
    logic [6:0] b;
    logic       t;
    logic       r;
    logic       ld;
    logic       sp;
    logic [1:0] s;
    logic [2:0] d;
    logic       on;
    logic       by;
  } vec_t;

  vec_t tv[12];

  // model state: 0 show, 1 spin, 2 tumble, 3 sleep
  int         m_mode, m_die, m_st, m_tt, m_done;
  logic [6:0] m_prev;

  function automatic logic [8:0] pk(
    input logic ld, input logic sp,
    input logic [1:0] s, input logic [2:0] d,
    input logic on, input logic by
  );
    return {ld, sp, s, d, on, by};
  endfunction

  function automatic logic [8:0] outv();
    return pk(bus.load, bus.step, bus.state,
              bus.die_sel, bus.disp_on, bus.busy);
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h, want %0h",
                  name, act, exp);
  endtask

  task automatic cyc(input logic [6:0] b,
                     input logic t, input logic r);
    bus.btn  = b;
    bus.tick = t;
    rst      = r;
    @(posedge clk);
    #1;
  endtask

  // Tumble step j lands when ticks since release reach j(j+1)/2.
  task automatic model(input logic [6:0] b, input logic t,
                       input logic r, output logic [8:0] e);
    logic [6:0] rise;
    logic ld, sp;
    ld = 1'b0;
    sp = 1'b0;
    rise = b & ~m_prev;
    m_prev = b;
    if (r) begin
      m_mode = 0; m_die = 0; m_st = 0; m_prev = '0;
    end else if (m_mode == 1) begin
      if (b[m_die]) sp = 1'b1;
      else begin
        m_mode = 2; m_tt = 0; m_done = 0;
      end
    end else if (rise != 0) begin
      ld = 1'b1;
      m_mode = 1;
      for (int i = 6; i >= 0; i--)
        if (rise[i]) m_die = i;
    end else if (t && m_mode == 0) begin
      m_st++;
      if (m_st == ST) m_mode = 3;
    end else if (t && m_mode == 2) begin
      m_tt++;
      if (m_tt == (m_done + 1) * (m_done + 2) / 2) begin
        sp = 1'b1;
        m_done++;
        if (m_done == N) begin
          m_mode = 0; m_st = 0;
        end
      end
    end
    e = pk(ld, sp, 2'(m_mode), 3'(m_die),
           m_mode == 0 || m_mode == 2,
           m_mode == 1 || m_mode == 2);
  endtask

  initial begin
    int steps, loads, ticks, last, bad, nst, rate;
    logic [6:0] b;
    logic t, r;
    logic [8:0] e;

    bus.btn  = '0;
    bus.tick = 1'b0;
    rst      = 1'b1;

    tv[0]  = '{7'h00, 0, 1, 0, 0, 0, 0, 1, 0};
    tv[1]  = '{7'h44, 0, 0, 1, 0, 1, 2, 0, 1};
    tv[2]  = '{7'h44, 0, 0, 0, 1, 1, 2, 0, 1};
    tv[3]  = '{7'h45, 0, 0, 0, 1, 1, 2, 0, 1};
    tv[4]  = '{7'h41, 0, 0, 0, 0, 2, 2, 1, 1};
    tv[5]  = '{7'h41, 0, 0, 0, 0, 2, 2, 1, 1};
    tv[6]  = '{7'h00, 1, 0, 0, 1, 2, 2, 1, 1};
    tv[7]  = '{7'h00, 1, 0, 0, 0, 2, 2, 1, 1};
    tv[8]  = '{7'h00, 1, 0, 0, 1, 2, 2, 1, 1};
    tv[9]  = '{7'h08, 1, 0, 1, 0, 1, 3, 0, 1};
    tv[10] = '{7'h08, 0, 0, 0, 1, 1, 3, 0, 1};
    tv[11] = '{7'h00, 0, 0, 0, 0, 2, 3, 1, 1};

    for (int i = 0; i < 12; i++) begin
      cyc(tv[i].b, tv[i].t, tv[i].r);
      chk($sformatf("vec%0d", i), outv(),
          pk(tv[i].ld, tv[i].sp, tv[i].s,
             tv[i].d, tv[i].on, tv[i].by));
    end

    // idle after reset until the show timeout
    cyc(7'h00, 0, 1);
    chk("rst_out", outv(), pk(0, 0, 0, 0, 1, 0));
    loads = 0;
    steps = 0;
    for (int i = 1; i < ST; i++) begin
      cyc(7'h00, 1, 0);
      loads += bus.load;
      steps += bus.step;
      cyc(7'h00, 0, 0);
      cyc(7'h00, 0, 0);
    end
    chk("idle_state", bus.state, 0);
    chk("idle_disp", bus.disp_on, 1);
    chk("idle_cmds", loads + steps, 0);
    cyc(7'h00, 1, 0);
    chk("sleep_state", bus.state, 3);
    chk("sleep_disp", bus.disp_on, 0);

    // d20 roll from sleep: 100 spin steps, then tumble
    cyc(7'h20, 0, 0);
    chk("d20_load", outv(), pk(1, 0, 1, 5, 0, 1));
    loads = 0;
    steps = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(7'h20, 0, 0);
      loads += bus.load;
      steps += bus.step;
    end
    chk("spin_steps", steps, 100);
    chk("spin_loads", loads, 0);
    cyc(7'h00, 0, 0);
    chk("rel_out", outv(), pk(0, 0, 2, 5, 1, 1));
    ticks = 0;
    last  = 0;
    bad   = 0;
    nst   = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(7'h00, 1, 0);
      ticks++;
      if (bus.step) begin
        nst++;
        if (ticks - last != nst) bad++;
        last = ticks;
      end
      if (bus.state == 0) break;
      cyc(7'h00, 0, 0);
      if (bus.step) bad++;
    end
    chk("tmb_steps", nst, N);
    chk("tmb_spacing", bad, 0);
    chk("tmb_ticks", ticks, N * (N + 1) / 2);
    chk("tmb_show", bus.state, 0);

    // press with coincident tick in SHOW
    cyc(7'h01, 1, 0);
    chk("tickpress", outv(), pk(1, 0, 1, 0, 0, 1));
    cyc(7'h01, 0, 0);
    chk("d4_step", bus.step, 1);

    // reset mid-spin with the button held
    cyc(7'h01, 0, 1);
    chk("midrst", outv(), pk(0, 0, 0, 0, 1, 0));
    cyc(7'h01, 0, 0);
    chk("rst_reload", outv(), pk(1, 0, 1, 0, 0, 1));

    // random phase against the model
    m_prev = '0;
    b = '0;
    model(b, 1'b0, 1'b1, e);
    cyc(b, 1'b0, 1'b1);
    chk("rnd_rst", outv(), e);
    for (int i = 0; i < 20000; i++) begin
      rate = (i < 10000) ? 30 : 700;
      if ($urandom_range(0, rate - 1) == 0)
        b[$urandom_range(0, 6)] ^= 1'b1;
      t = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 2999) == 0);
      model(b, t, r, e);
      cyc(b, t, r);
      chk("rnd", outv(), e);
      if (total_n - pass_n > 20) break;
    end

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
